// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: FSM state encoding, tick rate and default long-press length.
// Imported by stopwatch_ctrl; pure declarations, no logic.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } sw_state_t;

  localparam int TICK_HZ              = 1000;
  localparam int LONG_PRESS_TICKS_DEF = 2 * TICK_HZ;

endpackage

// File: rtl/stopwatch_ctrl_rise_detect.sv
// Rising-edge detector for a debounced button level.
// Latency: rise is combinational from level; the history bit updates every clock. No backpressure.
// The history bit resets to 1, so a button held through reset release never reads as a press.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b1;
    else        prev <= level;
  end

  assign rise = level & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear FSM for the stopwatch, with long-press clear. LAP_HOLD_EN enables lap hold.
// Latency: button edge before clock k -> registered outputs change after edge k (1 clock).
// No backpressure: count_clr is a one-cycle pulse and every other output is a level.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int LONG_PRESS_TICKS = LONG_PRESS_TICKS_DEF,
  parameter int LP_W             = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       clear,
  output logic       count_en,
  output logic       count_clr,
  output logic       disp_hold,
  output logic [1:0] state_o
);

  localparam logic [LP_W-1:0] LP_MAX  = LP_W'(LONG_PRESS_TICKS);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'(LONG_PRESS_TICKS - 1);

  sw_state_t       state, nxt;
  logic            ss_rise, clr_rise;
  logic            lp_active, lp_fire, lp_fired, clr_req;
  logic [LP_W-1:0] lp_cnt;

  rise_detect u_ss_rise (
    .clk   (clk),
    .reset (reset),
    .level (start_stop),
    .rise  (ss_rise)
  );

  rise_detect u_clr_rise (
    .clk   (clk),
    .reset (reset),
    .level (clear),
    .rise  (clr_rise)
  );

  assign lp_active = clear && ((state == RUN) || (state == LAP));
  assign lp_fire   = lp_active && tick && !lp_fired && (lp_cnt == LP_LAST);

  // The fired flag only clears when the button is released, so re-entering RUN
  // with clear still held cannot trigger a second long press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lp_cnt   <= '0;
      lp_fired <= 1'b0;
    end else begin
      if (!lp_active)                    lp_cnt <= '0;
      else if (tick && lp_cnt != LP_MAX) lp_cnt <= lp_cnt + LP_W'(1);

      if (!clear)       lp_fired <= 1'b0;
      else if (lp_fire) lp_fired <= 1'b1;
    end
  end

  // Priority: start_stop edge, then long press, then clear edge.
  always_comb begin
    nxt     = state;
    clr_req = 1'b0;
    case (state)
      IDLE: begin
        if (ss_rise)       nxt = RUN;
        else if (clr_rise) clr_req = 1'b1;
      end
      RUN: begin
        if (ss_rise) nxt = PAUSE;
        else if (lp_fire) begin
          nxt     = IDLE;
          clr_req = 1'b1;
        end
`ifdef LAP_HOLD_EN
        else if (clr_rise) nxt = LAP;
`endif
      end
      PAUSE: begin
        if (ss_rise) nxt = RUN;
        else if (clr_rise) begin
          nxt     = IDLE;
          clr_req = 1'b1;
        end
      end
      LAP: begin
`ifdef LAP_HOLD_EN
        if (ss_rise) nxt = PAUSE;
        else if (lp_fire) begin
          nxt     = IDLE;
          clr_req = 1'b1;
        end
        else if (clr_rise) nxt = RUN;
`else
        nxt = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      count_en  <= 1'b0;
      count_clr <= 1'b0;
      disp_hold <= 1'b0;
      state_o   <= 2'b00;
    end else begin
      state     <= nxt;
      count_en  <= (nxt == RUN) || (nxt == LAP);
      count_clr <= clr_req;
`ifdef LAP_HOLD_EN
      disp_hold <= (nxt == LAP);
`else
      disp_hold <= 1'b0;
`endif
      state_o   <= nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with LONG_PRESS_TICKS=4; checks {state_o, count_en, count_clr, disp_hold}.
// LAP expectations follow LAP_HOLD_EN.
module tb_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset, tick, start_stop, clear;
  logic       count_en, count_clr, disp_hold;
  logic [1:0] state_o;

  int n_asserts = 0;
  int n_fail    = 0;

  // Expected {state_o, count_en, count_clr, disp_hold}
  localparam logic [4:0] E_IDLE    = 5'b00_0_0_0;
  localparam logic [4:0] E_IDLECLR = 5'b00_0_1_0;
  localparam logic [4:0] E_RUN     = 5'b01_1_0_0;
  localparam logic [4:0] E_PAUSE   = 5'b10_0_0_0;
  localparam logic [4:0] E_LAP     = 5'b11_1_0_1;
`ifdef LAP_HOLD_EN
  localparam logic [4:0] E_RUN_CLR = E_LAP;
`else
  localparam logic [4:0] E_RUN_CLR = E_RUN;
`endif

  stopwatch_ctrl #(.LONG_PRESS_TICKS(4), .LP_W(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .start_stop (start_stop),
    .clear      (clear),
    .count_en   (count_en),
    .count_clr  (count_clr),
    .disp_hold  (disp_hold),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {state_o, count_en, count_clr, disp_hold};
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick_once();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; start_stop = 1'b1; clear = 1'b0;
    #1 chk("reset_async", E_IDLE);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // Button held through reset release is not a press
    cyc(); chk("held_ss_no_run", E_IDLE);
    cyc(); chk("held_ss_idle2", E_IDLE);
    start_stop = 1'b0; cyc(); chk("ss_release", E_IDLE);
    start_stop = 1'b1; cyc(); chk("ss_rise_run", E_RUN);
    cyc(); chk("ss_held_run", E_RUN);

    start_stop = 1'b0; cyc();
    start_stop = 1'b1; cyc(); chk("run_to_pause", E_PAUSE);
    start_stop = 1'b0;
    clear = 1'b1; cyc(); chk("pause_clr_idle", E_IDLECLR);
    cyc(); chk("clr_pulse_one_cycle", E_IDLE);
    clear = 1'b0; cyc(); chk("idle_quiet", E_IDLE);

    clear = 1'b1; cyc(); chk("idle_clr_pulse", E_IDLECLR);
    clear = 1'b0; cyc(); chk("idle_clr_done", E_IDLE);

`ifdef LAP_HOLD_EN
    start_stop = 1'b1; cyc(); start_stop = 1'b0; cyc();
    clear = 1'b1; cyc(); chk("run_to_lap", E_LAP);
    clear = 1'b0; cyc(); chk("lap_hold", E_LAP);
    clear = 1'b1; cyc(); chk("lap_to_run", E_RUN);
    clear = 1'b0; cyc();
    clear = 1'b1; cyc(); chk("run_to_lap2", E_LAP);
    clear = 1'b0; start_stop = 1'b1; cyc(); chk("lap_ss_pause", E_PAUSE);
    start_stop = 1'b0; cyc();
    start_stop = 1'b1; cyc(); start_stop = 1'b0;
    clear = 1'b1; cyc(); clear = 1'b0;
    start_stop = 1'b1; cyc(); chk("lap_ss_pause2", E_PAUSE);
    start_stop = 1'b0; cyc();
    clear = 1'b1; cyc(); chk("pause_clr_idle2", E_IDLECLR);
    clear = 1'b0; cyc();
`endif

    // Long press from RUN
    start_stop = 1'b1; cyc(); chk("idle_to_run", E_RUN);
    start_stop = 1'b0; cyc();
    clear = 1'b1; cyc(); chk("run_clr_edge", E_RUN_CLR);
    tick_once(); chk("lp_tick1", E_RUN_CLR);
    tick_once(); chk("lp_tick2", E_RUN_CLR);
    tick_once(); chk("lp_tick3", E_RUN_CLR);
    tick_once(); chk("lp_tick4_fire", E_IDLECLR);
    cyc(); chk("lp_pulse_end", E_IDLE);

    // Re-enter RUN with clear still held: fired flag blocks a second long press
    start_stop = 1'b1; cyc(); chk("run_clear_held", E_RUN);
    start_stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_once(); chk("lp_no_refire", E_RUN);
    end
    clear = 1'b0; cyc(); chk("clear_released", E_RUN);

    // Simultaneous ss and clr rise from PAUSE: start_stop wins
    start_stop = 1'b1; cyc(); chk("run_to_pause2", E_PAUSE);
    start_stop = 1'b0; cyc();
    start_stop = 1'b1; clear = 1'b1; cyc(); chk("both_rise_run", E_RUN);
    cyc(); chk("both_rise_no_clr", E_RUN);
    start_stop = 1'b0; clear = 1'b0; cyc();

    // Long-press fire coinciding with ss_rise loses to ss_rise
    clear = 1'b1; cyc(); chk("run_clr_edge2", E_RUN_CLR);
    tick_once(); tick_once(); tick_once(); chk("lp_pre_fire", E_RUN_CLR);
    tick = 1'b1; start_stop = 1'b1; cyc(); tick = 1'b0;
    chk("ss_beats_lp", E_PAUSE);
    start_stop = 1'b0; clear = 1'b0; cyc(); chk("pause_after_lp", E_PAUSE);

    // Async reset mid-RUN with partial long-press count
    start_stop = 1'b1; cyc(); chk("pause_to_run", E_RUN);
    start_stop = 1'b0; cyc();
    clear = 1'b1; cyc(); clear = 1'b0; cyc();
`ifdef LAP_HOLD_EN
    clear = 1'b1; cyc(); clear = 1'b0; cyc();
`endif
    chk("run_before_reset", E_RUN);
    clear = 1'b1; cyc(); cyc();
    tick_once(); tick_once();
    @(posedge clk); #3 reset = 1'b0;
    #1 chk("reset_mid_run", E_IDLE);
    @(posedge clk); #3 reset = 1'b1;
    cyc(); chk("after_reset_idle", E_IDLE);

    // Counter restarts from zero: three ticks must not fire
    start_stop = 1'b1; cyc(); chk("restart_run", E_RUN);
    start_stop = 1'b0;
    tick_once(); tick_once(); tick_once(); chk("restart_3ticks", E_RUN);
    tick_once(); chk("restart_4th_fire", E_IDLECLR);
    clear = 1'b0; cyc(); chk("final_idle", E_IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
